// File: rtl/multi_nibble_add_ctrl.sv
// Wide adder sequencer: drives one shared 4-bit full adder one nibble per clock,
// LSB nibble first, chaining the carry, with a start/busy/done handshake.
module multi_nibble_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   c_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum_out,
  output logic                   c_out,
  output logic [3:0]             adder_a,
  output logic [3:0]             adder_b,
  output logic                   adder_cin,
  input  logic [3:0]             adder_sum,
  input  logic                   adder_cout
);

  // A single-nibble build still needs a 1-bit index so the counter has a width.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [NIBBLES-1:0][3:0]   op_a;
  logic [NIBBLES-1:0][3:0]   op_b;
  logic [NIBBLES-1:0][3:0]   sum_q;
  logic                      carry;
  logic [IDX_W-1:0]          index;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (index == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder operands are only driven while adding so the shared adder sees zeros otherwise.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_cin = 1'b0;
    unique case (state_q)
      ADD: begin
        busy      = 1'b1;
        adder_a   = op_a[index];
        adder_b   = op_b[index];
        adder_cin = carry;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      index <= '0;
      c_out <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          op_a  <= a_in;
          op_b  <= b_in;
          carry <= c_in;
          index <= '0;
          sum_q <= '0;
          c_out <= 1'b0;
        end
        ADD: begin
          sum_q[index] <= adder_sum;
          carry        <= adder_cout;
          index        <= index + 1'b1;
          if (index == LAST) c_out <= adder_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum_out = sum_q;

endmodule

// File: tb/tb_multi_nibble_add_ctrl.sv
// Directed bench for multi_nibble_add_ctrl: a 4-nibble instance and a 1-nibble
// instance, each wired to its own behavioural 4-bit full adder.
module tb_multi_nibble_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        c_in;
  logic        busy, done, c_out;
  logic [15:0] sum_out;
  logic [3:0]  adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        cin1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  adder_a1, adder_b1, adder_sum1;
  logic        adder_cin1, adder_cout1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum}   = 5'(adder_a)  + 5'(adder_b)  + 5'(adder_cin);
  assign {adder_cout1, adder_sum1} = 5'(adder_a1) + 5'(adder_b1) + 5'(adder_cin1);

  multi_nibble_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .sum_out(sum_out), .c_out(c_out),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  multi_nibble_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .c_out(cout1),
    .adder_a(adder_a1), .adder_b(adder_b1), .adder_cin(adder_cin1),
    .adder_sum(adder_sum1), .adder_cout(adder_cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    start = 1'b1; a_in = a; b_in = b; c_in = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cout: got %b expected 0", c_out); end
    tests_run++; if ({adder_a, adder_b, adder_cin} !== 9'h000) begin tests_failed++; $display("[TB] FAIL reset_adder: got %h expected 000", {adder_a, adder_b, adder_cin}); end
    tests_run++; if ({busy1, done1, sum1, cout1} !== 7'h00) begin tests_failed++; $display("[TB] FAIL reset_n1: got %h expected 00", {busy1, done1, sum1, cout1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_b = '{4'h1, 4'h2, 4'h3, 4'h4};
    start_op(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy[%0d]: got %b expected 1", i, busy); end
      tests_run++; if (adder_a !== exp_a[i]) begin tests_failed++; $display("[TB] FAIL basic_adder_a[%0d]: got %h expected %h", i, adder_a, exp_a[i]); end
      tests_run++; if (adder_b !== exp_b[i]) begin tests_failed++; $display("[TB] FAIL basic_adder_b[%0d]: got %h expected %h", i, adder_b, exp_b[i]); end
      tick();
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_done: got %b expected 1", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_done: got %b expected 0", busy); end
    tests_run++; if (sum_out !== 16'h5555) begin tests_failed++; $display("[TB] FAIL basic_sum: got %h expected 5555", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_cout: got %b expected 0", c_out); end
    tests_run++; if (adder_a !== 4'h0) begin tests_failed++; $display("[TB] FAIL basic_adder_idle: got %h expected 0", adder_a); end
    tick();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    tests_run++; if (sum_out !== 16'h5555) begin tests_failed++; $display("[TB] FAIL basic_sum_hold: got %h expected 5555", sum_out); end
  endtask

  task automatic test_ripple();
    logic exp_cin [4];
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
    start_op(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (adder_cin !== exp_cin[i]) begin tests_failed++; $display("[TB] FAIL ripple_cin[%0d]: got %b expected %b", i, adder_cin, exp_cin[i]); end
      tick();
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL ripple_done: got %b expected 1", done); end
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL ripple_sum: got %h expected 0000", sum_out); end
    tests_run++; if (c_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL ripple_cout: got %b expected 1", c_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    tests_run++; if (adder_cin !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_cin: got %b expected 1", adder_cin); end
    repeat (4) tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
    tests_run++; if (sum_out !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL b2b_first_sum: got %h expected ffff", sum_out); end
    tests_run++; if (c_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_cout: got %b expected 1", c_out); end
    tick();
    start_op(16'h0000, 16'h0000, 1'b0);
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL b2b_accept_sum_clear: got %h expected 0000", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_accept_cout_clear: got %b expected 0", c_out); end
    tests_run++; if (adder_cin !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_stale_cin: got %b expected 0", adder_cin); end
    repeat (4) tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second_done: got %b expected 1", done); end
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL b2b_second_sum: got %h expected 0000", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second_cout: got %b expected 0", c_out); end
    tick();
  endtask

  task automatic test_start_held();
    logic [15:0] noise_a [4];
    logic [15:0] noise_b [4];
    noise_a = '{16'hA5A5, 16'hFFFF, 16'h8000, 16'h7777};
    noise_b = '{16'h5A5A, 16'hFFFF, 16'h8000, 16'h9999};
    start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; c_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      a_in = noise_a[i]; b_in = noise_b[i]; c_in = 1'b1;
      tick();
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL held_done: got %b expected 1", done); end
    tests_run++; if (sum_out !== 16'h3333) begin tests_failed++; $display("[TB] FAIL held_sum: got %h expected 3333", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL held_cout: got %b expected 0", c_out); end
    a_in = 16'h0F0F; b_in = 16'h0101; c_in = 1'b1;
    tick();
    tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("[TB] FAIL held_ignored_in_done: got %b expected 00", {busy, done}); end
    tests_run++; if (sum_out !== 16'h3333) begin tests_failed++; $display("[TB] FAIL held_sum_hold: got %h expected 3333", sum_out); end
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL held_next_accept: got %b expected 1", busy); end
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL held_next_clear: got %h expected 0000", sum_out); end
    repeat (4) tick();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL held_next_done: got %b expected 1", done); end
    tests_run++; if (sum_out !== 16'h1011) begin tests_failed++; $display("[TB] FAIL held_next_sum: got %h expected 1011", sum_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start_op(16'h1234, 16'h4321, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("[TB] FAIL rstmid_flags: got %b expected 00", {busy, done}); end
    tests_run++; if (sum_out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL rstmid_sum: got %h expected 0000", sum_out); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_cout: got %b expected 0", c_out); end
    tests_run++; if ({adder_a, adder_b, adder_cin} !== 9'h000) begin tests_failed++; $display("[TB] FAIL rstmid_adder: got %h expected 000", {adder_a, adder_b, adder_cin}); end
    rst = 1'b0;
    repeat (6) begin
      tick();
      if (done !== 1'b0) pulses++;
    end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", pulses); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_idle: got %b expected 0", busy); end
  endtask

  task automatic test_nibbles1();
    start1 = 1'b1; a1 = 4'hA; b1 = 4'h7; cin1 = 1'b1;
    tick();
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    tests_run++; if (busy1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL n1_busy: got %b expected 1", busy1); end
    tests_run++; if ({adder_a1, adder_b1, adder_cin1} !== 9'h14F) begin tests_failed++; $display("[TB] FAIL n1_adder: got %h expected 14f", {adder_a1, adder_b1, adder_cin1}); end
    tick();
    tests_run++; if ({busy1, done1} !== 2'b01) begin tests_failed++; $display("[TB] FAIL n1_done: got %b expected 01", {busy1, done1}); end
    tests_run++; if (sum1 !== 4'h2) begin tests_failed++; $display("[TB] FAIL n1_sum: got %h expected 2", sum1); end
    tests_run++; if (cout1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL n1_cout: got %b expected 1", cout1); end
    tick();
    tests_run++; if (done1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL n1_done_pulse: got %b expected 0", done1); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_nibbles1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
